// File: rtl/ring_control_sequencer_if.sv
// rtl/ring_control_sequencer_if.sv - ring/datapath signal bundle for the ring control sequencer
//
// Purpose: groups the phase vector, data-bus sample, ALU flag and all datapath
// control strobes exchanged between the accumulator CPU datapath/timing ring
// and the micro-sequencer.
//
// Members:
//   phase[NPH]       ungated one-hot ring state (Tk = phase[k])
//   bus_in[IRW]      data bus, captured into IR at the end of T2
//   alu_zero         ALU result-is-zero, captured at the end of ADD/SUB T5
//   pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load, opr_out,
//   acc_load, acc_out, b_load, alu_out, alu_sub, out_load   control strobes
//   restart          ring returns to T0 at the next posedge
//   halted           halt latch
//   opcode[4]        IR opcode field
//   operand[IRW-4]   IR operand field
//   phase_err        sticky illegal-phase flag
//
// Modports: master = ring/datapath side, slave = sequencer.

interface ring_control_sequencer_if #(
    parameter int NPH = 9,
    parameter int IRW = 8
);
    logic [NPH-1:0] phase;
    logic [IRW-1:0] bus_in;
    logic           alu_zero;

    logic           pc_out;
    logic           pc_inc;
    logic           pc_load;
    logic           mar_load;
    logic           mem_rd;
    logic           mem_wr;
    logic           ir_load;
    logic           opr_out;
    logic           acc_load;
    logic           acc_out;
    logic           b_load;
    logic           alu_out;
    logic           alu_sub;
    logic           out_load;
    logic           restart;
    logic           halted;
    logic [3:0]     opcode;
    logic [IRW-5:0] operand;
    logic           phase_err;

    modport master (
        output phase, bus_in, alu_zero,
        input  pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load,
               opr_out, acc_load, acc_out, b_load, alu_out, alu_sub, out_load,
               restart, halted, opcode, operand, phase_err
    );

    modport slave (
        input  phase, bus_in, alu_zero,
        output pc_out, pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load,
               opr_out, acc_load, acc_out, b_load, alu_out, alu_sub, out_load,
               restart, halted, opcode, operand, phase_err
    );
endinterface

// File: rtl/ring_control_sequencer.sv
// rtl/ring_control_sequencer.sv - micro-sequencer for the 8-bit accumulator CPU
//
// Purpose: decodes the 9-phase timing ring together with the instruction
// register into per-phase datapath control strobes, requests an early ring
// restart when an instruction completes, and holds IR, zero flag and halt latch.
//
// Ports:
//   clk    system clock, state updates on posedge
//   reset  asynchronous, active-high; clears IR, zflag, halted, phase_err
//   bus    ring_control_sequencer_if.slave (phase/bus_in/alu_zero in,
//          control strobes, restart, halted, opcode, operand, phase_err out)
//
// Build option: PHASE_CHECK_EN - when defined, a phase vector that is not
// exactly one-hot suppresses all outputs and state updates for that cycle and
// sets the sticky phase_err flag. When undefined, the lowest set phase bit is
// decoded and phase_err is tied to 0.

module ring_control_sequencer #(
    parameter int NPH = 9,
    parameter int IRW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    ring_control_sequencer_if.slave bus
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [IRW-1:0] ir;
    logic           zflag;
    logic           halted_r;
    logic [3:0]     op;

    // Single-hot view of the ring used by all decode below.
    logic [NPH-1:0] dec;
    logic           enable;
    logic           t0, t1, t2, t3, t4, t5;

    logic pc_out_c, pc_inc_c, pc_load_c, mar_load_c, mem_rd_c, mem_wr_c;
    logic ir_load_c, opr_out_c, acc_load_c, acc_out_c, b_load_c;
    logic alu_out_c, alu_sub_c, out_load_c, restart_c;

`ifdef PHASE_CHECK_EN
    logic phase_err_r;

    // Zero or multi-hot vectors decode to nothing.
    assign dec = $onehot(bus.phase) ? bus.phase : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_err_r <= 1'b0;
        end else if (!$onehot(bus.phase)) begin
            phase_err_r <= 1'b1;
        end
    end

    assign bus.phase_err = phase_err_r;
`else
    // Isolate the lowest set bit (x & -x); all-zero stays all-zero.
    assign dec = bus.phase & (~bus.phase + {{(NPH-1){1'b0}}, 1'b1});

    assign bus.phase_err = 1'b0;
`endif

    assign op     = ir[IRW-1:IRW-4];
    assign enable = !reset && !halted_r && (|dec);

    assign t0 = enable && dec[0];
    assign t1 = enable && dec[1];
    assign t2 = enable && dec[2];
    assign t3 = enable && dec[3];
    assign t4 = enable && dec[4];
    assign t5 = enable && dec[5];

    always_comb begin
        pc_out_c   = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        mar_load_c = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        ir_load_c  = 1'b0;
        opr_out_c  = 1'b0;
        acc_load_c = 1'b0;
        acc_out_c  = 1'b0;
        b_load_c   = 1'b0;
        alu_out_c  = 1'b0;
        alu_sub_c  = 1'b0;
        out_load_c = 1'b0;
        restart_c  = 1'b0;

        // Fetch is common to every opcode.
        if (t0) begin
            pc_out_c   = 1'b1;
            mar_load_c = 1'b1;
        end
        if (t1) begin
            pc_inc_c = 1'b1;
        end
        if (t2) begin
            mem_rd_c  = 1'b1;
            ir_load_c = 1'b1;
        end

        // Execute; phases past an instruction's restart phase fall through to 0.
        case (op)
            OP_LDA: begin
                if (t3) begin
                    opr_out_c  = 1'b1;
                    mar_load_c = 1'b1;
                end
                if (t4) begin
                    mem_rd_c   = 1'b1;
                    acc_load_c = 1'b1;
                    restart_c  = 1'b1;
                end
            end
            OP_ADD, OP_SUB: begin
                if (t3) begin
                    opr_out_c  = 1'b1;
                    mar_load_c = 1'b1;
                end
                if (t4) begin
                    mem_rd_c  = 1'b1;
                    b_load_c  = 1'b1;
                    alu_sub_c = (op == OP_SUB);
                end
                if (t5) begin
                    alu_out_c  = 1'b1;
                    acc_load_c = 1'b1;
                    restart_c  = 1'b1;
                    alu_sub_c  = (op == OP_SUB);
                end
            end
            OP_STA: begin
                if (t3) begin
                    opr_out_c  = 1'b1;
                    mar_load_c = 1'b1;
                end
                if (t4) begin
                    acc_out_c = 1'b1;
                    mem_wr_c  = 1'b1;
                    restart_c = 1'b1;
                end
            end
            OP_LDI: begin
                if (t3) begin
                    opr_out_c  = 1'b1;
                    acc_load_c = 1'b1;
                    restart_c  = 1'b1;
                end
            end
            OP_JMP: begin
                if (t3) begin
                    opr_out_c = 1'b1;
                    pc_load_c = 1'b1;
                    restart_c = 1'b1;
                end
            end
            OP_JZ: begin
                if (t3) begin
                    opr_out_c = zflag;
                    pc_load_c = zflag;
                    restart_c = 1'b1;
                end
            end
            OP_OUT: begin
                if (t3) begin
                    acc_out_c  = 1'b1;
                    out_load_c = 1'b1;
                    restart_c  = 1'b1;
                end
            end
            OP_HLT: begin
                // No strobes; the halt latch is set at the end of T3.
            end
            default: begin
                // NOP and unassigned opcodes 8..D.
                if (t3) begin
                    restart_c = 1'b1;
                end
            end
        endcase
    end

    // Strobes are already gated by reset/halted/phase validity, so the update
    // conditions inherit the freeze-while-halted and bad-phase rules.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir       <= '0;
            zflag    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            if (ir_load_c) begin
                ir <= bus.bus_in;
            end
            if (t5 && (op == OP_ADD || op == OP_SUB)) begin
                zflag <= bus.alu_zero;
            end
            if (t3 && op == OP_HLT) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign bus.pc_out   = pc_out_c;
    assign bus.pc_inc   = pc_inc_c;
    assign bus.pc_load  = pc_load_c;
    assign bus.mar_load = mar_load_c;
    assign bus.mem_rd   = mem_rd_c;
    assign bus.mem_wr   = mem_wr_c;
    assign bus.ir_load  = ir_load_c;
    assign bus.opr_out  = opr_out_c;
    assign bus.acc_load = acc_load_c;
    assign bus.acc_out  = acc_out_c;
    assign bus.b_load   = b_load_c;
    assign bus.alu_out  = alu_out_c;
    assign bus.alu_sub  = alu_sub_c;
    assign bus.out_load = out_load_c;
    assign bus.restart  = restart_c;
    assign bus.halted   = halted_r;
    assign bus.opcode   = op;
    assign bus.operand  = ir[IRW-5:0];

endmodule

// File: tb/tb_ring_control_sequencer.sv
// tb/tb_ring_control_sequencer.sv - self-checking bench for ring_control_sequencer

module tb_ring_control_sequencer;

    localparam int C_PC_OUT   = 14;
    localparam int C_PC_INC   = 13;
    localparam int C_PC_LOAD  = 12;
    localparam int C_MAR      = 11;
    localparam int C_MEM_RD   = 10;
    localparam int C_MEM_WR   = 9;
    localparam int C_IR_LOAD  = 8;
    localparam int C_OPR      = 7;
    localparam int C_ACC_LOAD = 6;
    localparam int C_ACC_OUT  = 5;
    localparam int C_B_LOAD   = 4;
    localparam int C_ALU_OUT  = 3;
    localparam int C_ALU_SUB  = 2;
    localparam int C_OUT_LOAD = 1;
    localparam int C_RESTART  = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    // Reference machine state
    logic [7:0] m_ir;
    logic       m_z;
    logic       m_halt;
    logic       m_err;

    ring_control_sequencer_if #(.NPH(9), .IRW(8)) bus ();

    ring_control_sequencer #(.NPH(9), .IRW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] sb(input int i);
        return 15'(1) << i;
    endfunction

    function automatic logic [14:0] get_ctrl();
        return {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_load, bus.mem_rd,
                bus.mem_wr, bus.ir_load, bus.opr_out, bus.acc_load, bus.acc_out,
                bus.b_load, bus.alu_out, bus.alu_sub, bus.out_load, bus.restart};
    endfunction

    function automatic logic [9:0] state_vec();
        return {bus.opcode, bus.operand, bus.halted, bus.phase_err};
    endfunction

    function automatic logic [9:0] model_state();
        return {m_ir, m_halt, m_err};
    endfunction

    // Phase the sequencer should act on, or -1 for none.
    function automatic int model_phase(input logic [8:0] p);
`ifdef PHASE_CHECK_EN
        if ($countones(p) != 1) return -1;
`endif
        for (int i = 0; i < 9; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Instruction table: strobes asserted in phase k for the current model state.
    function automatic logic [14:0] model_ctrl(input int k);
        logic [3:0] op = m_ir[7:4];
        if (m_halt || k < 0) return '0;
        if (k == 0) return sb(C_PC_OUT) | sb(C_MAR);
        if (k == 1) return sb(C_PC_INC);
        if (k == 2) return sb(C_MEM_RD) | sb(C_IR_LOAD);
        case (op)
            4'h1: if (k == 3) return sb(C_OPR) | sb(C_MAR);
                  else if (k == 4) return sb(C_MEM_RD) | sb(C_ACC_LOAD) | sb(C_RESTART);
            4'h2, 4'h3: begin
                if (k == 3) return sb(C_OPR) | sb(C_MAR);
                if (k == 4) return sb(C_MEM_RD) | sb(C_B_LOAD) | (op == 4'h3 ? sb(C_ALU_SUB) : 15'd0);
                if (k == 5) return sb(C_ALU_OUT) | sb(C_ACC_LOAD) | sb(C_RESTART) | (op == 4'h3 ? sb(C_ALU_SUB) : 15'd0);
            end
            4'h4: if (k == 3) return sb(C_OPR) | sb(C_MAR);
                  else if (k == 4) return sb(C_ACC_OUT) | sb(C_MEM_WR) | sb(C_RESTART);
            4'h5: if (k == 3) return sb(C_OPR) | sb(C_ACC_LOAD) | sb(C_RESTART);
            4'h6: if (k == 3) return sb(C_OPR) | sb(C_PC_LOAD) | sb(C_RESTART);
            4'h7: if (k == 3) return sb(C_RESTART) | (m_z ? (sb(C_OPR) | sb(C_PC_LOAD)) : 15'd0);
            4'hE: if (k == 3) return sb(C_ACC_OUT) | sb(C_OUT_LOAD) | sb(C_RESTART);
            4'hF: return '0;
            default: if (k == 3) return sb(C_RESTART);
        endcase
        return '0;
    endfunction

    function automatic void model_clock(input logic [8:0] p, input logic [7:0] b, input logic az);
        int k = model_phase(p);
        logic [3:0] op = m_ir[7:4];
`ifdef PHASE_CHECK_EN
        if ($countones(p) != 1) m_err = 1'b1;
`endif
        if (!m_halt && k >= 0) begin
            if (k == 2) m_ir = b;
            else if (k == 5 && (op == 4'h2 || op == 4'h3)) m_z = az;
            else if (k == 3 && op == 4'hF) m_halt = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        m_ir = '0; m_z = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    endfunction

    task automatic apply(input logic [8:0] p, input logic [7:0] b, input logic az);
        @(negedge clk);
        bus.phase = p; bus.bus_in = b; bus.alu_zero = az;
        #2;
    endtask

    task automatic advance();
        model_clock(bus.phase, bus.bus_in, bus.alu_zero);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.phase = 9'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.phase = 9'b1; bus.bus_in = 8'hFF; bus.alu_zero = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        nchk++; if (get_ctrl() !== 15'd0) begin nerr++; $display("FAIL reset_ctrl: got %h expected %h", get_ctrl(), 15'd0); end
        nchk++; if (state_vec() !== 10'd0) begin nerr++; $display("FAIL reset_state: got %h expected %h", state_vec(), 10'd0); end
        @(negedge clk);
        reset = 1'b0;
        #2;
        nchk++; if (get_ctrl() !== (sb(C_PC_OUT) | sb(C_MAR))) begin nerr++; $display("FAIL reset_release_T0: got %h expected %h", get_ctrl(), sb(C_PC_OUT) | sb(C_MAR)); end
    endtask

    task automatic test_lda();
        logic [14:0] exp;
        for (int k = 0; k <= 4; k++) begin
            apply(9'(1) << k, (k == 2) ? 8'h15 : 8'h00, 1'b0);
            exp = model_ctrl(k);
            nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL lda_ctrl_T%0d: got %h expected %h", k, get_ctrl(), exp); end
            if (k == 4) begin
                nchk++; if (get_ctrl() !== (sb(C_MEM_RD) | sb(C_ACC_LOAD) | sb(C_RESTART))) begin nerr++; $display("FAIL lda_T4_const: got %h expected %h", get_ctrl(), sb(C_MEM_RD) | sb(C_ACC_LOAD) | sb(C_RESTART)); end
            end
            advance();
            nchk++; if (state_vec() !== model_state()) begin nerr++; $display("FAIL lda_state_T%0d: got %h expected %h", k, state_vec(), model_state()); end
            if (k == 2) begin
                nchk++; if ({bus.opcode, bus.operand} !== 8'h15) begin nerr++; $display("FAIL lda_ir: got %h expected %h", {bus.opcode, bus.operand}, 8'h15); end
            end
        end
    endtask

    // Arithmetic instruction then JZ; jz_exp is the required JZ T3 strobe set.
    task automatic test_arith_jz(input logic [7:0] instr, input logic az, input logic [14:0] jz_exp);
        logic [14:0] exp;
        for (int k = 0; k <= 5; k++) begin
            apply(9'(1) << k, (k == 2) ? instr : 8'($urandom), (k == 5) ? az : 1'($urandom));
            exp = model_ctrl(k);
            nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL arith_%h_ctrl_T%0d: got %h expected %h", instr, k, get_ctrl(), exp); end
            advance();
        end
        for (int k = 0; k <= 3; k++) begin
            apply(9'(1) << k, (k == 2) ? 8'h79 : 8'h00, ~az);
            exp = model_ctrl(k);
            nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL jz_ctrl_T%0d: got %h expected %h", k, get_ctrl(), exp); end
            if (k == 3) begin
                nchk++; if (get_ctrl() !== jz_exp) begin nerr++; $display("FAIL jz_T3_const: got %h expected %h", get_ctrl(), jz_exp); end
                nchk++; if (bus.operand !== 4'h9) begin nerr++; $display("FAIL jz_operand: got %h expected %h", bus.operand, 4'h9); end
            end
            advance();
        end
    endtask

    task automatic test_sta_overrun();
        logic [14:0] exp;
        for (int k = 0; k <= 8; k++) begin
            apply(9'(1) << k, (k == 2) ? 8'h4C : 8'hA5, 1'b1);
            exp = model_ctrl(k);
            nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL sta_ctrl_T%0d: got %h expected %h", k, get_ctrl(), exp); end
            if (k >= 5) begin
                nchk++; if (get_ctrl() !== 15'd0) begin nerr++; $display("FAIL sta_overrun_T%0d: got %h expected %h", k, get_ctrl(), 15'd0); end
            end
            advance();
        end
    endtask

    task automatic test_halt();
        logic [14:0] exp;
        for (int k = 0; k <= 8; k++) begin
            apply(9'(1) << k, (k == 2) ? 8'hF0 : 8'h00, 1'b0);
            exp = model_ctrl(k);
            nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL hlt_ctrl_T%0d: got %h expected %h", k, get_ctrl(), exp); end
            advance();
            nchk++; if (state_vec() !== model_state()) begin nerr++; $display("FAIL hlt_state_T%0d: got %h expected %h", k, state_vec(), model_state()); end
        end
        nchk++; if (bus.halted !== 1'b1) begin nerr++; $display("FAIL hlt_latched: got %b expected %b", bus.halted, 1'b1); end
        for (int k = 0; k <= 3; k++) begin
            apply(9'(1) << k, 8'h15, 1'b1);
            nchk++; if (get_ctrl() !== 15'd0) begin nerr++; $display("FAIL hlt_frozen_T%0d: got %h expected %h", k, get_ctrl(), 15'd0); end
            advance();
        end
        nchk++; if (bus.opcode !== 4'hF) begin nerr++; $display("FAIL hlt_ir_frozen: got %h expected %h", bus.opcode, 4'hF); end
        apply(9'b10, 8'h00, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        nchk++; if ({bus.halted, bus.opcode} !== 5'd0) begin nerr++; $display("FAIL hlt_async_reset: got %h expected %h", {bus.halted, bus.opcode}, 5'd0); end
        bus.phase = 9'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bad_phase();
        logic [14:0] exp;
        for (int k = 0; k <= 3; k++) begin
            apply(9'(1) << k, (k == 2) ? 8'h57 : 8'h00, 1'b0);
            advance();
        end
        apply(9'b1, 8'h00, 1'b0); advance();
        apply(9'b10, 8'h00, 1'b0); advance();
        apply(9'b000000101, 8'hE0, 1'b0);
`ifdef PHASE_CHECK_EN
        exp = 15'd0;
`else
        exp = sb(C_PC_OUT) | sb(C_MAR);
`endif
        nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL badphase_ctrl: got %h expected %h", get_ctrl(), exp); end
        nchk++; if (get_ctrl() !== model_ctrl(model_phase(bus.phase))) begin nerr++; $display("FAIL badphase_model: got %h expected %h", get_ctrl(), model_ctrl(model_phase(bus.phase))); end
        advance();
        nchk++; if (bus.opcode !== 4'h5) begin nerr++; $display("FAIL badphase_ir: got %h expected %h", bus.opcode, 4'h5); end
        nchk++; if (state_vec() !== model_state()) begin nerr++; $display("FAIL badphase_state: got %h expected %h", state_vec(), model_state()); end
        apply(9'b100, 8'h23, 1'b0);
        advance();
        nchk++; if (state_vec() !== model_state()) begin nerr++; $display("FAIL badphase_sticky: got %h expected %h", state_vec(), model_state()); end
`ifdef PHASE_CHECK_EN
        nchk++; if (bus.phase_err !== 1'b1) begin nerr++; $display("FAIL badphase_err: got %b expected %b", bus.phase_err, 1'b1); end
`else
        nchk++; if (bus.phase_err !== 1'b0) begin nerr++; $display("FAIL badphase_err: got %b expected %b", bus.phase_err, 1'b0); end
`endif
    endtask

    // Random ring: honours restart most of the time, occasional glitches and resets.
    task automatic test_random();
        int k = 0;
        logic glitch;
        logic [8:0] p;
        logic [14:0] exp;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                reset = 1'b1;
                bus.phase = 9'b1;
                #1;
                model_reset();
                nchk++; if (get_ctrl() !== 15'd0) begin nerr++; $display("FAIL rand_reset_ctrl: got %h expected %h", get_ctrl(), 15'd0); end
                nchk++; if (state_vec() !== 10'd0) begin nerr++; $display("FAIL rand_reset_state: got %h expected %h", state_vec(), 10'd0); end
                @(negedge clk);
                reset = 1'b0;
                k = 0;
            end else begin
                glitch = ($urandom_range(0, 11) == 0);
                p = glitch ? 9'($urandom_range(0, 511)) : (9'(1) << k);
                apply(p, 8'($urandom), 1'($urandom));
                exp = model_ctrl(model_phase(p));
                nchk++; if (get_ctrl() !== exp) begin nerr++; $display("FAIL rand_ctrl n=%0d phase=%b: got %h expected %h", n, p, get_ctrl(), exp); end
                advance();
                nchk++; if (state_vec() !== model_state()) begin nerr++; $display("FAIL rand_state n=%0d: got %h expected %h", n, state_vec(), model_state()); end
                if (!glitch) k = (exp[C_RESTART] && $urandom_range(0, 3) != 0) ? 0 : (k + 1) % 9;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_arith_jz(8'h23, 1'b1, sb(C_OPR) | sb(C_PC_LOAD) | sb(C_RESTART));
        test_arith_jz(8'h31, 1'b0, sb(C_RESTART));
        test_sta_overrun();
        test_halt();
        do_reset();
        test_bad_phase();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ring_control_sequencer.md
Name: ring_control_sequencer

Overview:
- Micro-sequencer for the 8-bit accumulator CPU. It sits directly downstream of the 9-phase one-hot timing ring.
- Consumes the ring's ungated one-hot phase vector (T0..T8), captures the instruction, and emits per-phase datapath control strobes.
- Drives a restart request back to the ring so that short instructions return to T0 early.
- Holds the instruction register, the zero flag and the halt latch.

Parameters:
- NPH, 9, number of timing phases; width of the phase vector.
- IRW, 8, instruction width: opcode in [IRW-1:IRW-4], operand in [IRW-5:0].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- phase  in  NPH  ungated one-hot ring state; changes just after posedge clk; phase[k] high = Tk.
- bus_in  in  IRW  data bus, sampled into IR.
- alu_zero  in  1  ALU result-is-zero, sampled into the zero flag.
- pc_out, pc_inc, pc_load  out  1 each  program counter controls.
- mar_load, mem_rd, mem_wr  out  1 each  memory controls.
- ir_load, opr_out  out  1 each  IR load strobe; drive operand onto bus.
- operand  out  IRW-4  IR operand field, registered.
- acc_load, acc_out, b_load, alu_out, alu_sub, out_load  out  1 each  datapath controls.
- restart  out  1  combinational; ring returns to T0 at the next posedge.
- halted  out  1  halt latch.
- opcode  out  4  IR opcode field, registered.
- phase_err  out  1  sticky illegal-phase flag (see Optional Feature).

Behaviour:
- Reset: IR=0, zflag=0, halted=0, phase_err=0; all control outputs 0 combinationally while reset is high.
- Control outputs are combinational from (phase, IR, zflag, halted). Registers update at the posedge that ends the named phase.
- Fetch, all opcodes:
  - T0: pc_out, mar_load.
  - T1: pc_inc.
  - T2: mem_rd, ir_load; IR <= bus_in at the end of T2.
- Execute, by opcode:
  - 0 NOP: T3 restart.
  - 1 LDA: T3 opr_out+mar_load; T4 mem_rd+acc_load+restart.
  - 2 ADD: T3 opr_out+mar_load; T4 mem_rd+b_load; T5 alu_out+acc_load+restart; zflag <= alu_zero at the end of T5.
  - 3 SUB: as ADD, with alu_sub also high in T4 and T5.
  - 4 STA: T3 opr_out+mar_load; T4 acc_out+mem_wr+restart.
  - 5 LDI: T3 opr_out+acc_load+restart.
  - 6 JMP: T3 opr_out+pc_load+restart.
  - 7 JZ: T3 restart; opr_out+pc_load only if zflag=1.
  - E OUT: T3 acc_out+out_load+restart.
  - F HLT: no strobes; halted <= 1 at the end of T3.
  - 8–D: treated as NOP.
- Phases after an instruction's restart phase (ring ignored restart) assert nothing. T8 -> T0 wrap is handled by the ring.
- Halted: every control output and restart is forced to 0; IR and zflag are frozen; only reset clears halted.
- zflag is modified only by ADD/SUB.
- Reset asserted mid-instruction: immediate clear. The first instruction after release starts at whatever phase the ring presents; the ring is reset together with this block.

Optional Feature:
- Macro PHASE_CHECK_EN.
- Defined:
  - A phase vector that is not exactly one-hot (zero or multi-hot) suppresses all control outputs and restart for that cycle.
  - phase_err is set at that posedge and is sticky until reset.
  - No IR, zflag or halted update occurs in that cycle.
- Undefined:
  - phase_err is tied to 0.
  - Decode uses the lowest-index set bit of phase; an all-zero vector asserts nothing.

Test Plan:
- Reset, then phase T0..T2 with bus_in=8'h15 -> T0 pc_out+mar_load, T1 pc_inc, T2 mem_rd+ir_load; opcode=1, operand=5 after T2; T3 opr_out+mar_load; T4 mem_rd+acc_load+restart.
- ADD (8'h23) with alu_zero=1 at T5 -> T4 b_load, T5 alu_out+acc_load+restart; zflag=1; next JZ (8'h79) at T3 gives opr_out+pc_load+restart with operand=9.
- SUB (8'h31) with alu_zero=0, then JZ -> alu_sub high in T4 and T5; JZ T3 gives restart only, pc_load=0.
- HLT (8'hF0) -> halted=1 after T3; phases T4..T8 and a new T0..T3 assert no outputs; reset mid-run -> halted=0, opcode=0.
- STA (8'h4C), ring ignores restart and runs T5..T8 -> T4 acc_out+mem_wr+restart; T5..T8 all outputs 0.
- With PHASE_CHECK_EN: phase=9'b000000101 during T2 -> no ir_load, IR unchanged, phase_err=1 and remains 1; without the macro, same stimulus decodes as T0.
